mux_gate_sequencer: RTL
=======================

// Module: mux_gate_sequencer
// PURPOSE
//  Shares one W-bit 2:1 mux slice (two_one_mux per bit) among N_REQ requesters.
//  Each request is a bitwise logic op on operands a, b. The block builds the op
//  from one or two sequenced passes through the shared mux. Round-robin
//  arbitration picks the requester; a valid/ready response returns the result.
// PARAMETERS
//  N_REQ  4  number of requesters (>=2); IDW = $clog2(N_REQ) is a localparam
//  W      8  operand/result width in bits
// PORTS
//  clk         in   1          clock; all state updates on rising edge
//  rst         in   1          synchronous, active-high reset
//  req         in   N_REQ      request per requester; held until gnt seen
//  op          in   3*N_REQ    op code per requester, slice [3i+2:3i]
//  a           in   W*N_REQ    operand a per requester, slice [Wi+W-1:Wi]
//  b           in   W*N_REQ    operand b per requester, same slicing
//  gnt         out  N_REQ      one-hot, 1-cycle pulse: operands captured
//  resp_valid  out  1          result available; held until resp_ready
//  resp_ready  in   1          consumer accepts result
//  resp_id     out  IDW        index of the requester that owns the result
//  resp_y      out  W          result
//  resp_err    out  1          1 = illegal op code, resp_y = 0
//  busy        out  1          1 whenever state != IDLE
// BEHAVIOUR
//  Mux semantics: y = s ? i1 : i0, applied bitwise. bn = ~b is built as mux(1,0,b).
//  Ops with passes; the final pass has s=a:
//   0 NOT  (y=~b)   1 pass:  mux(1,0,b)
//   1 NAND          2 passes: bn; mux(1,bn,a)
//   2 NOR           2 passes: bn; mux(bn,0,a)
//   3 AND           1 pass:  mux(0,b,a)
//   4 OR            1 pass:  mux(b,1,a)
//   5 XOR           2 passes: bn; mux(b,bn,a)
//   6 XNOR          2 passes: bn; mux(bn,b,a)
//   7 illegal: no pass; resp_err=1
//  FSM states: IDLE, PASS1, PASS2, RESP.
//   IDLE: when any req is set at edge E:
//    - choose the winner round-robin, starting at ptr+1 mod N_REQ
//    - ptr <= winner; latch op/a/b/id; gnt <= onehot(winner) for 1 cycle
//    - next state: PASS1 for 2-pass ops, PASS2 for 1-pass ops, RESP for op 7
//   PASS1: tmp <= bn; go to PASS2.
//   PASS2: y_reg <= final mux output (all W bits); go to RESP.
//   RESP: resp_valid=1. id/y/err stay stable while resp_ready=0.
//    resp_valid & resp_ready -> IDLE.
//  Latency, measured from the IDLE sample cycle t:
//   gnt is high in t+1.
//   resp_valid rises in t+3 (2-pass), t+2 (1-pass) or t+1 (illegal).
//  req is ignored outside IDLE. Min gap from handshake cycle h to next gnt: gnt in h+2.
//  Reset (any state, including mid-pass):
//   - gnt=0, resp_valid=0, resp_id=0, resp_y=0, resp_err=0, busy=0
//   - state=IDLE, ptr=N_REQ-1 (requester 0 wins first)
//   - any in-flight op is dropped with no response
//  A requester that still holds req after its response is a new request.
//  Fairness: each continuously requesting port is served within N_REQ grants.
// STRUCTURE
//  Shared package gate_ops_pkg: OP_NOT..OP_XNOR, OP_ILLEGAL=3'd7, FSM state
//   encodings, helper function is_two_pass(op).
//  Sub-module rr_arbiter (N_REQ; req, ptr -> onehot grant, index); reused elsewhere.
//  Datapath: W instances of the existing two_one_mux via generate; the input
//   selects are driven by a combinational decode of (state, op).
// TESTING  (W=8, N_REQ=4)
//  1 After rst, req[0] NAND a=F0 b=CC -> gnt=0001 in t+1; resp_valid in t+3,
//    id=0, y=3F, err=0.
//  2 a=AA b=0F through ops 0..6 -> F0, F5, 50, 0A, AF, A5, 5A.
//  3 req=1111 held, all OR -> grant order 0,1,2,3,0; no port starved.
//  4 req[2] op=7 -> gnt=0100 and resp_valid in t+1, err=1, y=00, id=2.
//  5 resp_ready=0 for 5 cycles with req[1] pending -> resp fields stable, no gnt.
//    Handshake in cycle h -> gnt=0010 in h+2.
//  6 rst pulsed during PASS1 -> all outputs 0 next cycle, no resp.
//    With req=1001, requester 0 is granted first.

Source files
------------

// File: rtl/gate_ops_pkg.sv
`default_nettype none
//============================================================================
// Package  : gate_ops_pkg
// Purpose  : Op codes, FSM state encodings and pass-count helper shared by the
//            mux-based gate sequencer.
// Revision : 1.0 - initial release
//============================================================================
package gate_ops_pkg;

    localparam logic [2:0] OP_NOT     = 3'd0;
    localparam logic [2:0] OP_NAND    = 3'd1;
    localparam logic [2:0] OP_NOR     = 3'd2;
    localparam logic [2:0] OP_AND     = 3'd3;
    localparam logic [2:0] OP_OR      = 3'd4;
    localparam logic [2:0] OP_XOR     = 3'd5;
    localparam logic [2:0] OP_XNOR    = 3'd6;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_PASS1 = 2'd1;
    localparam state_t S_PASS2 = 2'd2;
    localparam state_t S_RESP  = 2'd3;

    // Ops that need ~b staged in a first pass before the final a-selected pass.
    function automatic logic is_two_pass(input logic [2:0] op);
        return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XOR) || (op == OP_XNOR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_gate_sequencer_if.sv
`default_nettype none
//============================================================================
// Interface : mux_gate_sequencer_if
// Purpose   : Request/grant and valid/ready response bundle of the sequencer.
// Revision  : 1.0 - initial release
//============================================================================
interface mux_gate_sequencer_if #(
    parameter int N_REQ = 4,
    parameter int W     = 8
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]   req;
    logic [3*N_REQ-1:0] op;
    logic [W*N_REQ-1:0] a;
    logic [W*N_REQ-1:0] b;
    logic [N_REQ-1:0]   gnt;
    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic [W-1:0]       resp_y;
    logic               resp_err;
    logic               busy;

    modport master (
        output req, op, a, b, resp_ready,
        input  gnt, resp_valid, resp_id, resp_y, resp_err, busy
    );

    modport slave (
        input  req, op, a, b, resp_ready,
        output gnt, resp_valid, resp_id, resp_y, resp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
//============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick; search starts just after i_ptr.
// Revision : 1.0 - initial release
//============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  wire logic [N_REQ-1:0] i_req,
    input  wire logic [IDW-1:0]   i_ptr,
    output logic      [N_REQ-1:0] o_gnt,
    output logic      [IDW-1:0]   o_idx,
    output logic                  o_any
);
    logic [IDW-1:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = IDW'((int'(i_ptr) + k) % N_REQ);
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/two_one_mux.sv
`default_nettype none
//============================================================================
// Module   : two_one_mux
// Purpose  : Single-bit 2:1 multiplexer, o_y = i_sel ? i_d1 : i_d0.
// Revision : 1.0 - initial release
//============================================================================
module two_one_mux (
    input  wire logic i_d0,
    input  wire logic i_d1,
    input  wire logic i_sel,
    output logic      o_y
);
    assign o_y = i_sel ? i_d1 : i_d0;
endmodule
`default_nettype wire

// File: rtl/mux_gate_sequencer.sv
`default_nettype none
//============================================================================
// Module   : mux_gate_sequencer
// Purpose  : Evaluates per-requester bitwise logic ops by sequencing passes
//            through one shared W-bit 2:1 mux slice, round-robin arbitrated.
// Revision : 1.0 - initial release
//============================================================================
module mux_gate_sequencer #(
    parameter int N_REQ = 4,
    parameter int W     = 8
) (
    input wire logic            clk,
    input wire logic            rst,
    mux_gate_sequencer_if.slave bus
);
    import gate_ops_pkg::*;

    localparam int IDW = $clog2(N_REQ);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id;
    logic [2:0]       r_op;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_tmp;
    logic [W-1:0]     r_y;
    logic             r_err;
    logic [N_REQ-1:0] r_gnt;

    logic [N_REQ-1:0] w_arb_gnt;
    logic [IDW-1:0]   w_arb_idx;
    logic             w_arb_any;
    logic             w_take;
    logic [2:0]       w_win_op;
    logic [W-1:0]     w_i0;
    logic [W-1:0]     w_i1;
    logic [W-1:0]     w_s;
    logic [W-1:0]     w_mux_y;

    logic [2:0]       w_op_arr [N_REQ];
    logic [W-1:0]     w_a_arr  [N_REQ];
    logic [W-1:0]     w_b_arr  [N_REQ];

    for (genvar gp = 0; gp < N_REQ; gp++) begin : g_unpack
        assign w_op_arr[gp] = bus.op[3*gp +: 3];
        assign w_a_arr[gp]  = bus.a[W*gp +: W];
        assign w_b_arr[gp]  = bus.b[W*gp +: W];
    end

    rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    assign w_win_op = w_op_arr[w_arb_idx];
    assign w_take   = (r_state == S_IDLE) && w_arb_any;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_arb_any) begin
                    if (w_win_op == OP_ILLEGAL)    w_state_nxt = S_RESP;
                    else if (is_two_pass(w_win_op)) w_state_nxt = S_PASS1;
                    else                            w_state_nxt = S_PASS2;
                end
            end
            S_PASS1: w_state_nxt = S_PASS2;
            S_PASS2: w_state_nxt = S_RESP;
            S_RESP:  if (bus.resp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Default selects build ~b = mux(1,0,b); PASS2 overrides per op with s=a.
    always_comb begin
        w_i0 = '1;
        w_i1 = '0;
        w_s  = r_b;
        if (r_state == S_PASS2) begin
            case (r_op)
                OP_NAND: begin w_i0 = '1;    w_i1 = r_tmp; w_s = r_a; end
                OP_NOR:  begin w_i0 = r_tmp; w_i1 = '0;    w_s = r_a; end
                OP_AND:  begin w_i0 = '0;    w_i1 = r_b;   w_s = r_a; end
                OP_OR:   begin w_i0 = r_b;   w_i1 = '1;    w_s = r_a; end
                OP_XOR:  begin w_i0 = r_b;   w_i1 = r_tmp; w_s = r_a; end
                OP_XNOR: begin w_i0 = r_tmp; w_i1 = r_b;   w_s = r_a; end
                default: begin w_i0 = '1;    w_i1 = '0;    w_s = r_b; end
            endcase
        end
    end

    for (genvar gi = 0; gi < W; gi++) begin : g_mux
        two_one_mux u_mux (
            .i_d0  (w_i0[gi]),
            .i_d1  (w_i1[gi]),
            .i_sel (w_s[gi]),
            .o_y   (w_mux_y[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt <= '0;
            r_ptr <= IDW'(N_REQ - 1);
            r_id  <= '0;
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_tmp <= '0;
            r_y   <= '0;
            r_err <= 1'b0;
        end else begin
            r_gnt <= w_take ? w_arb_gnt : '0;
            if (w_take) begin
                r_ptr <= w_arb_idx;
                r_id  <= w_arb_idx;
                r_op  <= w_win_op;
                r_a   <= w_a_arr[w_arb_idx];
                r_b   <= w_b_arr[w_arb_idx];
                r_y   <= '0;
                r_err <= (w_win_op == OP_ILLEGAL);
            end
            if (r_state == S_PASS1) r_tmp <= w_mux_y;
            if (r_state == S_PASS2) r_y   <= w_mux_y;
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_id    = r_id;
    assign bus.resp_y     = r_y;
    assign bus.resp_err   = r_err;
    assign bus.busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire
